// File: rtl/sensor_conditioner.sv
// rtl/sensor_conditioner.sv - six-channel debounced hysteresis flagger with starvation watchdog
//
// Purpose: turns six raw ADC sample streams into debounced 1-bit event flags with
// hysteresis, and forces the fail-safe PPG flag when samples stop arriving.
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   sample_valid               one-cycle strobe, all six *_raw inputs carry a new sample
//   imu/accel/fsr/emg/flex_raw channel samples compared against TH_ON/TH_OFF
//   ppg_raw                    PPG sample compared against PPG_TH_ON/PPG_TH_OFF
//   IMU,Accel,FSR,EMG,Flex,PPG registered debounced flags
//   flags_valid                pulses the cycle after each accepted sample
//   stale                      no sample for TIMEOUT_CYC cycles
module sensor_conditioner #(
   parameter int DATA_W      = 10,
   parameter int TH_ON       = 512,
   parameter int TH_OFF      = 448,
   parameter int PPG_TH_ON   = 800,
   parameter int PPG_TH_OFF  = 700,
   parameter int DEB_N       = 3,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] imu_raw,
   input  logic [DATA_W-1:0] accel_raw,
   input  logic [DATA_W-1:0] fsr_raw,
   input  logic [DATA_W-1:0] emg_raw,
   input  logic [DATA_W-1:0] flex_raw,
   input  logic [DATA_W-1:0] ppg_raw,
   output logic              IMU,
   output logic              Accel,
   output logic              FSR,
   output logic              EMG,
   output logic              Flex,
   output logic              PPG,
   output logic              flags_valid,
   output logic              stale
);

   localparam int NCH  = 6;
   localparam int PPG_CH = 5;
   localparam int CW   = $clog2(DEB_N + 1);
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_ARMING    = 2'd1;
   localparam logic [1:0] ST_ACTIVE    = 2'd2;
   localparam logic [1:0] ST_RELEASING = 2'd3;

   localparam logic [DATA_W-1:0] ON_W      = DATA_W'(TH_ON);
   localparam logic [DATA_W-1:0] OFF_W     = DATA_W'(TH_OFF);
   localparam logic [DATA_W-1:0] PPG_ON_W  = DATA_W'(PPG_TH_ON);
   localparam logic [DATA_W-1:0] PPG_OFF_W = DATA_W'(PPG_TH_OFF);
   localparam logic [CW-1:0]     DEB_W     = CW'(DEB_N);
   localparam logic [CW-1:0]     CNT_MAX   = {CW{1'b1}};
   localparam logic [WD_W-1:0]   TO_W      = WD_W'(TIMEOUT_CYC);
   localparam logic [WD_W-1:0]   TO_M1_W   = WD_W'(TIMEOUT_CYC - 1);

   logic [DATA_W-1:0] raw [NCH];
   logic [NCH-1:0]    above;
   logic [NCH-1:0]    below;

   logic [1:0]      state_q [NCH];
   logic [1:0]      state_d [NCH];
   logic [CW-1:0]   cnt_q   [NCH];
   logic [CW-1:0]   cnt_d   [NCH];
   logic [NCH-1:0]  flag_q, flag_d;
   logic            flags_valid_q, flags_valid_d;
   logic            stale_q, stale_d;
   logic [WD_W-1:0] wd_q, wd_d;

   assign raw[0] = imu_raw;
   assign raw[1] = accel_raw;
   assign raw[2] = fsr_raw;
   assign raw[3] = emg_raw;
   assign raw[4] = flex_raw;
   assign raw[5] = ppg_raw;

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         if (i == PPG_CH) begin
            above[i] = raw[i] >= PPG_ON_W;
            below[i] = raw[i] <  PPG_OFF_W;
         end else begin
            above[i] = raw[i] >= ON_W;
            below[i] = raw[i] <  OFF_W;
         end
      end
   end

   always_comb begin
      logic [1:0]    cur;
      logic [CW-1:0] c;
      logic [CW-1:0] c_inc;
      cur           = ST_IDLE;
      c             = '0;
      c_inc         = '0;
      stale_d       = stale_q;
      wd_d          = wd_q;
      flags_valid_d = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
      end

      if (sample_valid) begin
         // A sample always wins over the watchdog, even on the timeout edge.
         wd_d          = '0;
         stale_d       = 1'b0;
         flags_valid_d = 1'b1;
         for (int i = 0; i < NCH; i++) begin
            // The recovery sample is evaluated as if the channel were idle.
            cur   = stale_q ? ST_IDLE : state_q[i];
            c     = stale_q ? '0 : cnt_q[i];
            c_inc = (c == CNT_MAX) ? c : c + 1'b1;
            case (cur)
               ST_IDLE: begin
                  if (above[i]) begin
                     state_d[i] = (DEB_N == 1) ? ST_ACTIVE : ST_ARMING;
                     cnt_d[i]   = (DEB_N == 1) ? '0 : CW'(1);
                  end else begin
                     state_d[i] = ST_IDLE;
                     cnt_d[i]   = '0;
                  end
               end
               ST_ARMING: begin
                  if (above[i] && c_inc >= DEB_W) begin
                     state_d[i] = ST_ACTIVE;
                     cnt_d[i]   = '0;
                  end else if (above[i]) begin
                     state_d[i] = ST_ARMING;
                     cnt_d[i]   = c_inc;
                  end else begin
                     state_d[i] = ST_IDLE;
                     cnt_d[i]   = '0;
                  end
               end
               ST_ACTIVE: begin
                  if (below[i]) begin
                     state_d[i] = (DEB_N == 1) ? ST_IDLE : ST_RELEASING;
                     cnt_d[i]   = (DEB_N == 1) ? '0 : CW'(1);
                  end else begin
                     state_d[i] = ST_ACTIVE;
                     cnt_d[i]   = '0;
                  end
               end
               default: begin
                  if (below[i] && c_inc >= DEB_W) begin
                     state_d[i] = ST_IDLE;
                     cnt_d[i]   = '0;
                  end else if (below[i]) begin
                     state_d[i] = ST_RELEASING;
                     cnt_d[i]   = c_inc;
                  end else begin
                     state_d[i] = ST_ACTIVE;
                     cnt_d[i]   = '0;
                  end
               end
            endcase
         end
      end else begin
         if (wd_q < TO_W) begin
            wd_d = wd_q + 1'b1;
         end
         if (wd_q == TO_M1_W) begin
            stale_d = 1'b1;
         end
         if (stale_d) begin
            for (int i = 0; i < NCH; i++) begin
               state_d[i] = ST_IDLE;
               cnt_d[i]   = '0;
            end
         end
      end

      for (int i = 0; i < NCH; i++) begin
         flag_d[i] = (state_d[i] == ST_ACTIVE) || (state_d[i] == ST_RELEASING);
      end
      // Fail-safe: heat-only mode while starved of samples.
      if (stale_d) begin
         flag_d = 6'b100000;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) begin
            state_q[i] <= ST_IDLE;
            cnt_q[i]   <= '0;
         end
         flag_q        <= '0;
         flags_valid_q <= 1'b0;
         stale_q       <= 1'b0;
         wd_q          <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         flag_q        <= flag_d;
         flags_valid_q <= flags_valid_d;
         stale_q       <= stale_d;
         wd_q          <= wd_d;
      end
   end

   assign IMU         = flag_q[0];
   assign Accel       = flag_q[1];
   assign FSR         = flag_q[2];
   assign EMG         = flag_q[3];
   assign Flex        = flag_q[4];
   assign PPG         = flag_q[5];
   assign flags_valid = flags_valid_q;
   assign stale       = stale_q;

endmodule
